// File: rtl/cdc_src_packer_pkg.sv
// Shared types for the source-side packer feeding the clearable gray-code CDC FIFO.
// Holds the accumulator state encoding, the count-width helper and a default payload struct.
package cdc_src_packer_pkg;

    typedef enum logic [1:0] {
        ACC_EMPTY  = 2'd0,
        ACC_FILL   = 2'd1,
        ACC_CLOSED = 2'd2
    } acc_state_e;

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    localparam int DEF_IN_WIDTH   = 8;
    localparam int DEF_PACK_RATIO = 4;

    // FIFO payload for the default geometry; other geometries declare the same shape locally.
    typedef struct packed {
        logic [DEF_IN_WIDTH*DEF_PACK_RATIO-1:0]  data;
        logic [cnt_width(DEF_PACK_RATIO)-1:0]    cnt;
        logic                                    last;
    } word_t;

endpackage

// File: rtl/cdc_src_packer_timer.sv
// Saturating idle counter; expire_o is high while the count sits at TIMEOUT.
// Latency: expire one cycle after the TIMEOUT-th counted cycle; no handshake, never stalls.
// TIMEOUT=0 removes the counter and ties expire_o low.
module cdc_src_packer_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic src_clk_i,
    input  logic src_rst_ni,
    input  logic clear_i,
    input  logic restart_i,
    output logic expire_o
);

    if (TIMEOUT > 0) begin : g_tmr
        localparam int TW = $clog2(TIMEOUT + 1);
        localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

        logic [TW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear_i || restart_i) begin
                cnt_d = '0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + TW'(1);
            end
        end

        always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
            if (!src_rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expire_o = (cnt_q == LIMIT);
    end else begin : g_no_tmr
        assign expire_o = 1'b0;
    end

endmodule

// File: rtl/cdc_src_packer.sv
// Packs PACK_RATIO narrow beats into one word (partial on in_last_i / idle timeout) for the CDC FIFO.
// Latency: closing beat in cycle t -> out_valid_o in t+2 with a free slot; 1 beat/cycle sustained.
// Backpressure: accumulator + one output slot; in_ready_o drops when both are full or a clear is pending.
// Optional: CDC_SRC_PACKER_STATS_EN adds stat_words_o / stat_dropped_o counters.
module cdc_src_packer
    import cdc_src_packer_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int PACK_RATIO = 4,
    parameter int TIMEOUT    = 16,
    localparam int CntW      = cnt_width(PACK_RATIO),
    localparam int OutW      = IN_WIDTH * PACK_RATIO
) (
    input  logic                src_clk_i,
    input  logic                src_rst_ni,
    input  logic                clear_i,
    input  logic                clear_pending_i,
    input  logic [IN_WIDTH-1:0] in_data_i,
    input  logic                in_last_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OutW-1:0]     out_data_o,
    output logic [CntW-1:0]     out_cnt_o,
    output logic                out_last_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
`ifdef CDC_SRC_PACKER_STATS_EN
    ,
    output logic [31:0]         stat_words_o,
    output logic [31:0]         stat_dropped_o
`endif
);

    typedef struct packed {
        logic [OutW-1:0] data;
        logic [CntW-1:0] cnt;
        logic            last;
    } slot_t;

    acc_state_e      acc_state_q;
    logic [OutW-1:0] acc_data_q;
    logic [CntW-1:0] acc_cnt_q;
    logic            acc_last_q;
    slot_t           slot_q;
    logic            slot_vld_q;
    logic            rdy_en_q;

    logic            acc_closed, out_hs, transfer, accept;
    logic            tmr_expire, tmr_restart;
    logic [CntW-1:0] base_cnt, fill_cnt;
    logic [OutW-1:0] base_data, fill_data;
    logic            fill_closes;

    assign acc_closed  = (acc_state_q == ACC_CLOSED);
    assign out_valid_o = slot_vld_q & ~clear_pending_i;
    assign out_hs      = out_valid_o & out_ready_i & ~clear_i;
    assign transfer    = acc_closed & (~slot_vld_q | out_hs);
    assign in_ready_o  = rdy_en_q & ~clear_pending_i & ~clear_i & (~acc_closed | transfer);
    assign accept      = in_valid_i & in_ready_o;

    // A beat arriving while the closed word leaves starts a fresh word in lane 0.
    always_comb begin
        base_cnt  = transfer ? '0 : acc_cnt_q;
        base_data = transfer ? '0 : acc_data_q;
        fill_data = base_data;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (base_cnt == CntW'(k)) begin
                fill_data[k*IN_WIDTH +: IN_WIDTH] = in_data_i;
            end
        end
        fill_cnt    = base_cnt + CntW'(1);
        fill_closes = in_last_i | (fill_cnt == CntW'(PACK_RATIO))
                    | (tmr_expire & (acc_state_q == ACC_FILL));
    end

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            acc_state_q <= ACC_EMPTY;
            acc_data_q  <= '0;
            acc_cnt_q   <= '0;
            acc_last_q  <= 1'b0;
        end else if (clear_i) begin
            acc_state_q <= ACC_EMPTY;
            acc_data_q  <= '0;
            acc_cnt_q   <= '0;
            acc_last_q  <= 1'b0;
        end else if (accept) begin
            acc_data_q  <= fill_data;
            acc_cnt_q   <= fill_cnt;
            acc_last_q  <= in_last_i;
            acc_state_q <= fill_closes ? ACC_CLOSED : ACC_FILL;
        end else if (transfer) begin
            acc_state_q <= ACC_EMPTY;
            acc_data_q  <= '0;
            acc_cnt_q   <= '0;
            acc_last_q  <= 1'b0;
        end else if ((acc_state_q == ACC_FILL) && tmr_expire) begin
            acc_state_q <= ACC_CLOSED;
        end
    end

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (clear_i) begin
                slot_q     <= '0;
                slot_vld_q <= 1'b0;
            end else if (transfer) begin
                slot_q     <= '{data: acc_data_q, cnt: acc_cnt_q, last: acc_last_q};
                slot_vld_q <= 1'b1;
            end else if (out_hs) begin
                slot_vld_q <= 1'b0;
            end
        end
    end

    assign tmr_restart = accept | (acc_state_q != ACC_FILL);

    cdc_src_packer_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .src_clk_i  (src_clk_i),
        .src_rst_ni (src_rst_ni),
        .clear_i    (clear_i),
        .restart_i  (tmr_restart),
        .expire_o   (tmr_expire)
    );

    assign out_data_o = slot_q.data;
    assign out_cnt_o  = slot_q.cnt;
    assign out_last_o = slot_q.last;

`ifdef CDC_SRC_PACKER_STATS_EN
    logic [31:0] stat_words_q, stat_dropped_q;

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            stat_words_q   <= '0;
            stat_dropped_q <= '0;
        end else begin
            if (out_hs) begin
                stat_words_q <= stat_words_q + 32'd1;
            end
            if (clear_i) begin
                stat_dropped_q <= stat_dropped_q + 32'(acc_cnt_q)
                                + (slot_vld_q ? 32'(slot_q.cnt) : 32'd0);
            end
        end
    end

    assign stat_words_o   = stat_words_q;
    assign stat_dropped_o = stat_dropped_q;
`endif

endmodule

// File: tb/tb_cdc_src_packer.sv
// Scoreboard bench for cdc_src_packer: a beat-list model predicts words, a negedge monitor compares them.
module tb_cdc_src_packer;

    localparam int W  = 8;
    localparam int PR = 4;
    localparam int TO = 16;
    localparam int CW = 3;
    localparam int OW = W * PR;

    logic          src_clk_i = 1'b0;
    logic          src_rst_ni;
    logic          clear_i, clear_pending_i;
    logic [W-1:0]  in_data_i;
    logic          in_last_i, in_valid_i, in_ready_o;
    logic [OW-1:0] out_data_o;
    logic [CW-1:0] out_cnt_o;
    logic          out_last_o, out_valid_o, out_ready_i;
`ifdef CDC_SRC_PACKER_STATS_EN
    logic [31:0]   stat_words_o, stat_dropped_o;
`endif

    cdc_src_packer #(.IN_WIDTH(W), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
        .src_clk_i       (src_clk_i),
        .src_rst_ni      (src_rst_ni),
        .clear_i         (clear_i),
        .clear_pending_i (clear_pending_i),
        .in_data_i       (in_data_i),
        .in_last_i       (in_last_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .out_data_o      (out_data_o),
        .out_cnt_o       (out_cnt_o),
        .out_last_o      (out_last_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i)
`ifdef CDC_SRC_PACKER_STATS_EN
        ,
        .stat_words_o    (stat_words_o),
        .stat_dropped_o  (stat_dropped_o)
`endif
    );

    always #5 src_clk_i = ~src_clk_i;

    typedef struct {
        logic [OW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
    } word_s;

    word_s        exp_q[$];
    logic [W-1:0] part_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int idle = 0;
    int words_exp = 0;
    int dropped_exp = 0;
    bit rand_rdy = 0;
    bit fixed_rdy = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void close_word(input logic last);
        word_s w;
        w.data = '0;
        foreach (part_q[i]) w.data[i*W +: W] = part_q[i];
        w.cnt  = CW'(part_q.size());
        w.last = last;
        exp_q.push_back(w);
        part_q.delete();
    endfunction

    // Monitor / reference model: runs on the negedge, away from the sampling edge.
    logic          prev_vld = 1'b0;
    logic          prev_hs  = 1'b0;
    logic [OW+CW:0] prev_word = '0;
    always @(negedge src_clk_i) begin
        if (!src_rst_ni) begin
            part_q.delete();
            exp_q.delete();
            idle = 0;
            words_exp = 0;
            dropped_exp = 0;
            prev_vld = 1'b0;
        end else if (clear_i) begin
            dropped_exp += part_q.size();
            foreach (exp_q[i]) dropped_exp += int'(exp_q[i].cnt);
            part_q.delete();
            exp_q.delete();
            idle = 0;
            prev_vld = 1'b0;
        end else begin
            if (prev_vld && !prev_hs && !clear_pending_i)
                check("hold", {out_valid_o, out_data_o, out_cnt_o, out_last_o}, {1'b1, prev_word});
            if (out_valid_o && out_ready_i) begin
                words_exp++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got data 0x%0h cnt %0d, expected none", out_data_o, out_cnt_o);
                end else begin
                    word_s w;
                    w = exp_q.pop_front();
                    check("word", {out_data_o, out_cnt_o, out_last_o}, {w.data, w.cnt, w.last});
                end
            end
            if (in_valid_i && in_ready_o) begin
                part_q.push_back(in_data_i);
                idle = 0;
                if (in_last_i || part_q.size() == PR) close_word(in_last_i);
            end else if (part_q.size() > 0) begin
                idle++;
                if (idle >= TO) begin
                    close_word(1'b0);
                    idle = 0;
                end
            end
            prev_vld  = out_valid_o;
            prev_hs   = out_valid_o & out_ready_i;
            prev_word = {out_data_o, out_cnt_o, out_last_o};
        end
    end

    initial begin
        out_ready_i = 1'b0;
        forever begin
            @(posedge src_clk_i);
            #1;
            out_ready_i = rand_rdy ? ($urandom_range(0, 9) < 7) : fixed_rdy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge src_clk_i);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, output int stall);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        stall = 0;
        @(negedge src_clk_i);
        while (!in_ready_o && stall < 200) begin
            stall++;
            @(negedge src_clk_i);
        end
        if (stall >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: beat 0x%0h not accepted in 200 cycles, expected acceptance", d);
        end
        @(posedge src_clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    initial begin
        int st, tot, anyv, w0;
        src_rst_ni = 1'b0;
        clear_i = 1'b0;
        clear_pending_i = 1'b0;
        in_data_i = '0;
        in_last_i = 1'b0;
        in_valid_i = 1'b0;

        #12;
        check("rst_outputs", {in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_last_o}, 64'd0);
        tick(2);
        src_rst_ni = 1'b1;
        tick(1);
        check("rdy_after_rst", in_ready_o, 1);

        // Full words, no stalls
        tot = 0;
        w0 = words_exp;
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), 1'b0, st);
            tot += st;
        end
        tick(5);
        check("full_stall", tot, 0);
        check("full_words", words_exp - w0, 2);

        // Last-closed partial word and its latency
        send(8'hAA, 1'b0, st);
        send(8'hBB, 1'b1, st);
        @(negedge src_clk_i);
        check("lat_t1", out_valid_o, 0);
        @(negedge src_clk_i);
        check("lat_t2", out_valid_o, 1);
        tick(3);

        // Idle timeout
        w0 = words_exp;
        send(8'h55, 1'b0, st);
        anyv = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge src_clk_i);
            if (out_valid_o) anyv++;
        end
        check("tmo_early", anyv, 0);
        tick(30);
        check("tmo_words", words_exp - w0, 1);

        // Backpressure
        fixed_rdy = 1'b0;
        tick(1);
        tot = 0;
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), 1'b0, st);
            tot += st;
        end
        check("bp_accept8", tot, 0);
        in_valid_i = 1'b1;
        in_data_i  = 8'h09;
        for (int i = 0; i < 4; i++) begin
            @(negedge src_clk_i);
            check("bp_stall", {in_ready_o, out_data_o}, {1'b0, 32'h04030201});
        end
        fixed_rdy = 1'b1;
        for (int i = 9; i <= 12; i++) send(W'(i), 1'b0, st);
        tick(6);

        // Clear with pending window
        fixed_rdy = 1'b0;
        tick(1);
        for (int i = 1; i <= 4; i++) send(W'(i), 1'b0, st);
        send(8'h21, 1'b0, st);
        send(8'h22, 1'b0, st);
        tick(2);
        clear_i = 1'b1;
        clear_pending_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'h77;
        in_last_i  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge src_clk_i);
            check("pend_gate", {in_ready_o, out_valid_o}, 2'b00);
            @(posedge src_clk_i);
            #1;
        end
        clear_pending_i = 1'b0;
        fixed_rdy = 1'b1;
        send(8'h77, 1'b1, st);
        tick(5);
`ifdef CDC_SRC_PACKER_STATS_EN
        check("stat_dropped", stat_dropped_o, 32'(dropped_exp));
        check("stat_words", stat_words_o, 32'(words_exp));
`endif

        // Asynchronous reset mid-word
        for (int i = 0; i < 3; i++) send(8'hC0 + W'(i), 1'b0, st);
        src_rst_ni = 1'b0;
        #2;
        check("rst_mid", {in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_last_o}, 64'd0);
        tick(2);
        src_rst_ni = 1'b1;
        tick(40);
        check("rst_no_stale", words_exp, 0);

        // Random traffic with random output backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 3));
            send(W'($urandom_range(0, 255)), $urandom_range(0, 4) == 0, st);
        end
        rand_rdy = 1'b0;
        fixed_rdy = 1'b1;
        tick(60);
        check("drain", exp_q.size() + part_q.size(), 0);
`ifdef CDC_SRC_PACKER_STATS_EN
        check("stat_words_end", stat_words_o, 32'(words_exp));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
